serial2parallel_deser: RTL and testbench

Serial-to-parallel deserializer that sits directly downstream of the team's parallel-to-serial shifter. It collects an LSB-first bit stream qualified by a valid strobe into WIDTH-bit words and presents each word on a valid/ready output port. A one-word holding register sits behind the collector, and the block flags overrun and broken-frame conditions.

---
 rtl/serial2parallel_deser_pkg.sv | 20 ++
 rtl/serial2parallel_deser_if.sv | 39 +++
 rtl/serial2parallel_deser_hold.sv | 64 ++++++
 rtl/serial2parallel_deser.sv | 99 +++++++++
 tb/tb_serial2parallel_deser.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/serial2parallel_deser_pkg.sv
// ----------------------------------------------------------------------------
// deser_pkg
// Shared types and defaults for the serial-to-parallel deserializer slice.
//   deser_state_t        : collector FSM state encoding
//   DESER_DEFAULT_WIDTH  : default word width in bits
//   deser_cnt_w()        : width of the bit counter for a given word width
// ----------------------------------------------------------------------------
package deser_pkg;

    typedef enum logic {DS_IDLE, DS_SHIFT} deser_state_t;

    localparam int DESER_DEFAULT_WIDTH = 8;

    // One extra bit over $clog2 so the counter never truncates, even when
    // WIDTH is an exact power of two.
    function automatic int deser_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial2parallel_deser_if.sv
// ----------------------------------------------------------------------------
// serial2parallel_deser_if
// Bundles the serial input, the valid/ready word output and the status flags.
//   ser_in, ser_valid : serial bit stream (LSB first) and its qualifier
//   data_out          : assembled word, stable while out_valid=1
//   out_valid         : data_out holds an unconsumed word
//   out_ready         : consumer accepts data_out when out_valid=1
//   overrun           : one-cycle pulse, completed word dropped (holder full)
//   frame_err         : one-cycle pulse, partial word discarded
//   bit_cnt           : bits of the current word collected so far
// Modports: master = stream source / word consumer, slave = deserializer.
// ----------------------------------------------------------------------------
interface serial2parallel_deser_if
    import deser_pkg::*;
#(
    parameter int WIDTH = DESER_DEFAULT_WIDTH
);
    localparam int CNT_W = deser_cnt_w(WIDTH);

    logic             ser_in;
    logic             ser_valid;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             frame_err;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output ser_in, ser_valid, out_ready,
        input  data_out, out_valid, overrun, frame_err, bit_cnt
    );

    modport slave (
        input  ser_in, ser_valid, out_ready,
        output data_out, out_valid, overrun, frame_err, bit_cnt
    );

endinterface

// File: rtl/serial2parallel_deser_hold.sv
// ----------------------------------------------------------------------------
// s2p_hold_stage
// One-word valid/ready holding register behind the collector.
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : a completed word is offered this edge
//   data_i    : the completed word
//   ready_i   : consumer ready
//   data_o    : held word (retains last value after consumption)
//   valid_o   : held word not yet consumed
//   overrun_o : one-cycle pulse, offered word dropped because holder was full
// ----------------------------------------------------------------------------
module s2p_hold_stage
    import deser_pkg::*;
#(
    parameter int WIDTH = DESER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (load_i) begin
            // A consume on the same edge frees the slot for the new word.
            if (!valid_q || ready_i) begin
                data_d  = data_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/serial2parallel_deser.sv
// ----------------------------------------------------------------------------
// serial2parallel_deser
// Collects an LSB-first serial stream into WIDTH-bit words and presents them
// through a one-word valid/ready holding register.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial2parallel_deser_if.slave (serial in, word out, status flags)
// ----------------------------------------------------------------------------
module serial2parallel_deser
    import deser_pkg::*;
#(
    parameter int WIDTH = DESER_DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    serial2parallel_deser_if.slave       bus
);

    localparam int CNT_W = deser_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    deser_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ferr_q, ferr_d;
    logic             word_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        ferr_d    = 1'b0;
        word_done = 1'b0;
        case (state_q)
            DS_IDLE: begin
                // WIDTH >= 2, so the first bit can never complete a word.
                if (bus.ser_valid) begin
                    shreg_d = {bus.ser_in, shreg_q[WIDTH-1:1]};
                    cnt_d   = CNT_W'(1);
                    state_d = DS_SHIFT;
                end
            end
            DS_SHIFT: begin
                if (bus.ser_valid) begin
                    shreg_d = {bus.ser_in, shreg_q[WIDTH-1:1]};
                    if (cnt_q == LAST_CNT) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = DS_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Bits of a word must be contiguous: drop the partial word.
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = DS_IDLE;
                end
            end
            default: begin
                state_d = DS_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DS_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
        end
    end

    // The word handed over includes the bit sampled on the completing edge,
    // so the holder loads shreg_d rather than shreg_q.
    s2p_hold_stage #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load_i    (word_done),
        .data_i    (shreg_d),
        .ready_i   (bus.out_ready),
        .data_o    (bus.data_out),
        .valid_o   (bus.out_valid),
        .overrun_o (bus.overrun)
    );

    assign bus.frame_err = ferr_q;
    assign bus.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_serial2parallel_deser.sv
// ----------------------------------------------------------------------------
// tb_serial2parallel_deser
// Directed bench for serial2parallel_deser with WIDTH=8. Inputs change on the
// falling edge; outputs are checked on the falling edge after the rising edge
// that produced them.
// ----------------------------------------------------------------------------
module tb_serial2parallel_deser;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    serial2parallel_deser_if #(.WIDTH(WIDTH)) bus ();

    serial2parallel_deser #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge; returns on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        bus.ser_valid = 1'b1;
        bus.ser_in    = b;
        tick();
    endtask

    task automatic idle_cycle();
        bus.ser_valid = 1'b0;
        bus.ser_in    = 1'b0;
        tick();
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic ovr, input logic ferr);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
        check({tag, ".data"},  64'(bus.data_out),  64'(d));
        check({tag, ".ovr"},   64'(bus.overrun),   64'(ovr));
        check({tag, ".ferr"},  64'(bus.frame_err), 64'(ferr));
    endtask

    initial begin
        logic [15:0] pair;
        logic [7:0]  w;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.ser_in    = 1'b0;
        bus.ser_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset.bit_cnt", 64'(bus.bit_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // Basic word: 1,0,1,0,0,1,0,1 LSB first -> 0xA5
        bus.out_ready = 1'b1;
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            drive_bit(w[i]);
            if (i == 2) check("basic.bit_cnt3", 64'(bus.bit_cnt), 64'd3);
            if (i == 6) check_out("basic.pre", 1'b0, 8'h00, 1'b0, 1'b0);
        end
        check_out("basic.done", 1'b1, 8'hA5, 1'b0, 1'b0);
        check("basic.bit_cnt0", 64'(bus.bit_cnt), 64'd0);
        idle_cycle();
        check_out("basic.consumed", 1'b0, 8'hA5, 1'b0, 1'b0);

        // Back-to-back 0x3C then 0xC3, no gap
        pair = 16'hC33C;
        for (int i = 0; i < 16; i++) begin
            drive_bit(pair[i]);
            if (i == 7)  check_out("b2b.w0", 1'b1, 8'h3C, 1'b0, 1'b0);
            if (i == 8)  check_out("b2b.gap", 1'b0, 8'h3C, 1'b0, 1'b0);
            if (i == 8)  check("b2b.bit_cnt1", 64'(bus.bit_cnt), 64'd1);
            if (i == 15) check_out("b2b.w1", 1'b1, 8'hC3, 1'b0, 1'b0);
        end
        idle_cycle();
        check_out("b2b.drain", 1'b0, 8'hC3, 1'b0, 1'b0);

        // Overrun: 0x11 then 0x22 with out_ready low
        bus.out_ready = 1'b0;
        pair = 16'h2211;
        for (int i = 0; i < 16; i++) begin
            drive_bit(pair[i]);
            if (i == 7)  check_out("ovr.w0", 1'b1, 8'h11, 1'b0, 1'b0);
            if (i == 14) check_out("ovr.pre", 1'b1, 8'h11, 1'b0, 1'b0);
            if (i == 15) check_out("ovr.hit", 1'b1, 8'h11, 1'b1, 1'b0);
        end
        idle_cycle();
        check_out("ovr.pulse_end", 1'b1, 8'h11, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        idle_cycle();
        check_out("ovr.drain", 1'b0, 8'h11, 1'b0, 1'b0);
        idle_cycle();
        check_out("ovr.empty", 1'b0, 8'h11, 1'b0, 1'b0);

        // Completion and consume on the same edge: hold 0x55, then 0xAA
        bus.out_ready = 1'b0;
        w = 8'h55;
        for (int i = 0; i < 8; i++) drive_bit(w[i]);
        check_out("sim.hold", 1'b1, 8'h55, 1'b0, 1'b0);
        w = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) bus.out_ready = 1'b1;
            drive_bit(w[i]);
            if (i == 6) check_out("sim.wait", 1'b1, 8'h55, 1'b0, 1'b0);
        end
        check_out("sim.swap", 1'b1, 8'hAA, 1'b0, 1'b0);
        idle_cycle();
        check_out("sim.drain", 1'b0, 8'hAA, 1'b0, 1'b0);

        // Frame error: 5 bits, one gap, then a clean 0x81
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        check("ferr.bit_cnt5", 64'(bus.bit_cnt), 64'd5);
        idle_cycle();
        check_out("ferr.pulse", 1'b0, 8'hAA, 1'b0, 1'b1);
        check("ferr.bit_cnt0", 64'(bus.bit_cnt), 64'd0);
        w = 8'h81;
        for (int i = 0; i < 8; i++) begin
            drive_bit(w[i]);
            if (i == 0) check_out("ferr.clear", 1'b0, 8'hAA, 1'b0, 1'b0);
        end
        check_out("ferr.word", 1'b1, 8'h81, 1'b0, 1'b0);

        // Reset mid-word: 3 bits, async reset, then 0x0F
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        check("rstmid.bit_cnt3", 64'(bus.bit_cnt), 64'd3);
        bus.ser_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_out("rstmid.async", 1'b0, 8'h00, 1'b0, 1'b0);
        check("rstmid.bit_cnt", 64'(bus.bit_cnt), 64'd0);
        tick();
        rst = 1'b0;
        idle_cycle();
        check_out("rstmid.after", 1'b0, 8'h00, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        w = 8'h0F;
        for (int i = 0; i < 8; i++) drive_bit(w[i]);
        check_out("rstmid.word", 1'b1, 8'h0F, 1'b0, 1'b0);
        idle_cycle();
        check_out("rstmid.drain", 1'b0, 8'h0F, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
